// File: rtl/dal_sched_pkg.sv
// Shared types and constants for the stage-2 DAL stage sequencer.
package dal_sched_pkg;
    localparam int PARA       = 8;
    localparam int NUM_STAGES = 7;
    localparam int STAGE_W    = $clog2(NUM_STAGES + 1);

    localparam logic [STAGE_W-1:0] STAGE_FIN   = STAGE_W'(NUM_STAGES);
    localparam logic [STAGE_W-1:0] STAGE_MATCH = STAGE_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_e;

    typedef logic [PARA-1:0] stage_len_t;
    typedef stage_len_t [NUM_STAGES-1:0] stage_cfg_t;
endpackage

// File: rtl/pipe_stage_sched_if.sv
// Controller/datapath bundle of the stage sequencer.
// STAGE_PERF_CNT_EN adds the per-stage stall counters.
interface pipe_stage_sched_if;
    import dal_sched_pkg::*;

    logic               start_i;
    stage_cfg_t         cfg_len_i;
    logic               adv_i;
    logic               busy_o;
    logic [STAGE_W-1:0] stage_o;
    stage_len_t         step_o;
    logic               stage_first_o;
    logic               stage_last_o;
    logic               mode_o;
    logic               finished_o;
    logic               done_o;
`ifdef STAGE_PERF_CNT_EN
    logic [NUM_STAGES-1:0][15:0] stall_cnt_o;

    modport master (
        output start_i, cfg_len_i, adv_i,
        input  busy_o, stage_o, step_o, stage_first_o, stage_last_o,
        input  mode_o, finished_o, done_o, stall_cnt_o
    );
    modport slave (
        input  start_i, cfg_len_i, adv_i,
        output busy_o, stage_o, step_o, stage_first_o, stage_last_o,
        output mode_o, finished_o, done_o, stall_cnt_o
    );
`else
    modport master (
        output start_i, cfg_len_i, adv_i,
        input  busy_o, stage_o, step_o, stage_first_o, stage_last_o,
        input  mode_o, finished_o, done_o
    );
    modport slave (
        input  start_i, cfg_len_i, adv_i,
        output busy_o, stage_o, step_o, stage_first_o, stage_last_o,
        output mode_o, finished_o, done_o
    );
`endif
endinterface

// File: rtl/stage_skip_enc.sv
// Finds the lowest nonzero-length stage at/above a base stage.
module stage_skip_enc
    import dal_sched_pkg::*;
(
    input  logic [NUM_STAGES-1:0] mask,
    input  logic [STAGE_W-1:0]    cur,
    input  logic                  incl,
    output logic [STAGE_W-1:0]    nxt,
    output logic                  none
);
    logic [NUM_STAGES-1:0] cand;

    // incl selects the start entry (cur itself eligible) vs. advance
    always_comb begin
        cand = '0;
        nxt  = STAGE_FIN;
        for (int i = 0; i < NUM_STAGES; i++) begin
            cand[i] = mask[i] &&
                ((STAGE_W'(i) > cur) || (incl && STAGE_W'(i) == cur));
        end
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (cand[i]) nxt = STAGE_W'(i);
        end
        none = ~|cand;
    end
endmodule

// File: rtl/pipe_stage_sched.sv
// Handshaked stage sequencer with per-stage beat budgets.
// Optional STAGE_PERF_CNT_EN: per-stage saturating stall counters.
module pipe_stage_sched
    import dal_sched_pkg::*;
(
    input logic               clk,
    input logic               rst,
    pipe_stage_sched_if.slave bus
);
    sched_state_e          state;
    logic [STAGE_W-1:0]    stage_q;
    stage_len_t            step_q;
    stage_cfg_t            len_q;
    logic                  done_q;
    logic [NUM_STAGES-1:0] run_mask;
    logic [NUM_STAGES-1:0] start_mask;
    logic [NUM_STAGES-1:0] enc_mask;
    logic [STAGE_W-1:0]    enc_cur;
    logic [STAGE_W-1:0]    enc_nxt;
    logic                  enc_none;
    stage_len_t            cur_len;
    logic                  is_idle;
    logic                  is_run;
    logic                  is_last;

    always_comb begin
        run_mask   = '0;
        start_mask = '0;
        cur_len    = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            run_mask[i]   = |len_q[i];
            start_mask[i] = |bus.cfg_len_i[i];
            if (stage_q == STAGE_W'(i)) cur_len = len_q[i];
        end
    end

    assign is_idle  = (state == IDLE);
    assign is_run   = (state == RUN);
    assign is_last  = (step_q == cur_len - PARA'(1));
    assign enc_mask = is_idle ? start_mask : run_mask;
    assign enc_cur  = is_idle ? '0 : stage_q;

    // One encoder serves both the start entry and the stage advance
    stage_skip_enc u_enc (
        .mask (enc_mask),
        .cur  (enc_cur),
        .incl (is_idle),
        .nxt  (enc_nxt),
        .none (enc_none)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            stage_q <= '0;
            step_q  <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            unique case (state)
                IDLE: if (bus.start_i) begin
                    len_q   <= bus.cfg_len_i;
                    step_q  <= '0;
                    stage_q <= enc_nxt;
                    state   <= enc_none ? DONE : RUN;
                end
                RUN: if (bus.adv_i) begin
                    if (is_last) begin
                        step_q  <= '0;
                        stage_q <= enc_nxt;
                        if (enc_none) state <= DONE;
                    end else begin
                        step_q <= step_q + PARA'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o        = !is_idle;
    assign bus.stage_o       = stage_q;
    assign bus.step_o        = step_q;
    assign bus.stage_first_o = is_run && (step_q == '0);
    assign bus.stage_last_o  = is_run && is_last;
    assign bus.mode_o        = !(is_run && stage_q == STAGE_MATCH);
    assign bus.finished_o    = (state == DONE);
    assign bus.done_o        = done_q;

`ifdef STAGE_PERF_CNT_EN
    logic [NUM_STAGES-1:0][15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (is_idle && bus.start_i) begin
            stall_q <= '0;
        end else if (is_run && !bus.adv_i) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (stage_q == STAGE_W'(i) && stall_q[i] != 16'hFFFF)
                    stall_q[i] <= stall_q[i] + 16'd1;
            end
        end
    end

    assign bus.stall_cnt_o = stall_q;
`endif
endmodule

// File: tb/tb_pipe_stage_sched.sv
// Directed self-checking bench for pipe_stage_sched.
module tb_pipe_stage_sched;
    import dal_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    pipe_stage_sched_if bus();

    pipe_stage_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setlen(input int l0, input int l1, input int l2,
                          input int l3, input int l4, input int l5,
                          input int l6);
        bus.cfg_len_i[0] = PARA'(l0);
        bus.cfg_len_i[1] = PARA'(l1);
        bus.cfg_len_i[2] = PARA'(l2);
        bus.cfg_len_i[3] = PARA'(l3);
        bus.cfg_len_i[4] = PARA'(l4);
        bus.cfg_len_i[5] = PARA'(l5);
        bus.cfg_len_i[6] = PARA'(l6);
    endtask

    task automatic go;
        bus.start_i = 1'b1;
        tick;
        bus.start_i = 1'b0;
    endtask

    initial begin
        int         n;
        int         fin_at;
        int         m0;
        int         maxstep;
        int         last_at;
        int         scnt [8];
        logic [20:0] seq;
        logic [63:0] stepseq;
        logic [7:0]  fseq;
        logic [7:0]  lseq;

        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.adv_i = 1'b0;
        setlen(0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_stage", bus.stage_o, 0);
        chk("rst_step", bus.step_o, 0);
        chk("rst_mode", bus.mode_o, 1);
        chk("rst_fin", bus.finished_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_fl", {bus.stage_first_o, bus.stage_last_o}, 0);
        rst = 1'b0;
        tick;

        // lengths 1..7, adv held high
        setlen(1, 2, 3, 4, 5, 6, 7);
        bus.adv_i = 1'b1;
        go;
        n = 1;
        chk("a_entry", {bus.busy_o, bus.stage_o, bus.step_o}, {1'b1, 3'd0, 8'd0});
        chk("a_fl", {bus.stage_first_o, bus.stage_last_o}, 2'b11);
        foreach (scnt[i]) scnt[i] = 0;
        m0 = 0;
        fin_at = 0;
        for (int k = 0; k < 40 && fin_at == 0; k++) begin
            if (bus.finished_o) begin
                fin_at = n;
            end else begin
                scnt[bus.stage_o]++;
                if (!bus.mode_o) m0++;
                tick;
                n++;
            end
        end
        chk("a_fin_at", fin_at, 29);
        chk("a_fin_stage", bus.stage_o, 7);
        chk("a_s0", scnt[0], 1);
        chk("a_s3", scnt[3], 4);
        chk("a_s6", scnt[6], 7);
        chk("a_mode0", m0, 2);
        tick;
        chk("a_done", {bus.done_o, bus.busy_o, bus.finished_o}, 3'b100);
        chk("a_idle_stage", bus.stage_o, 7);
        tick;
        chk("a_done_pulse", bus.done_o, 0);

        // zero-length stages skipped without bubbles
        setlen(2, 0, 0, 3, 0, 0, 1);
        go;
        seq = '0;
        m0 = 0;
        for (int k = 0; k < 7; k++) begin
            seq = {seq[17:0], bus.stage_o};
            if (!bus.mode_o) m0++;
            if (k < 6) tick;
        end
        chk("b_seq", seq, {3'd0, 3'd0, 3'd3, 3'd3, 3'd3, 3'd6, 3'd7});
        chk("b_mode0", m0, 0);
        tick;
        chk("b_done", bus.done_o, 1);
        tick;

        // all lengths zero
        setlen(0, 0, 0, 0, 0, 0, 0);
        go;
        chk("c_fin", {bus.finished_o, bus.busy_o, bus.stage_o}, {2'b11, 3'd7});
        chk("c_mode", bus.mode_o, 1);
        tick;
        chk("c_done", {bus.done_o, bus.finished_o, bus.busy_o}, 3'b100);
        tick;
        chk("c_done_pulse", bus.done_o, 0);

        // stage 1 with alternating adv, stray start mid-run
        setlen(0, 4, 0, 0, 0, 0, 0);
        bus.adv_i = 1'b0;
        go;
        stepseq = '0;
        fseq = '0;
        lseq = '0;
        m0 = 0;
        for (int k = 0; k < 8; k++) begin
            stepseq = {stepseq[55:0], bus.step_o};
            fseq = {fseq[6:0], bus.stage_first_o};
            lseq = {lseq[6:0], bus.stage_last_o};
            if (!bus.mode_o && bus.stage_o == 3'd1) m0++;
            if (k == 2) begin
                bus.start_i = 1'b1;
                setlen(1, 1, 1, 1, 1, 1, 1);
            end
            if (k == 3) bus.start_i = 1'b0;
            bus.adv_i = (k % 2 == 1);
            tick;
        end
        chk("d_steps", stepseq, 64'h0000010102020303);
        chk("d_first", fseq, 8'b11000000);
        chk("d_last", lseq, 8'b00000011);
        chk("d_mode0", m0, 8);
        chk("d_fin", {bus.finished_o, bus.stage_o}, {1'b1, 3'd7});
`ifdef STAGE_PERF_CNT_EN
        chk("d_stall1", bus.stall_cnt_o[1], 4);
        chk("d_stall0", bus.stall_cnt_o[0], 0);
`endif
        bus.adv_i = 1'b1;
        tick;
        chk("d_done", bus.done_o, 1);
        tick;

        // maximum length: step reaches 2^PARA-2
        setlen(0, 0, 0, 0, 0, 0, 255);
        go;
        n = 1;
        fin_at = 0;
        maxstep = 0;
        last_at = 0;
        for (int k = 0; k < 300 && fin_at == 0; k++) begin
            if (bus.finished_o) begin
                fin_at = n;
            end else begin
                if (int'(bus.step_o) > maxstep) maxstep = int'(bus.step_o);
                if (bus.stage_last_o && last_at == 0) last_at = n;
                tick;
                n++;
            end
        end
        chk("f_fin_at", fin_at, 256);
        chk("f_maxstep", maxstep, 254);
        chk("f_last_at", last_at, 255);
        tick;
        tick;

        // reset while in stage 3
        setlen(1, 1, 1, 5, 0, 0, 0);
        go;
        tick;
        tick;
        tick;
        tick;
        chk("e_pre", {bus.stage_o, bus.step_o}, {3'd3, 8'd1});
        rst = 1'b1;
        #1;
        chk("e_async", {bus.busy_o, bus.stage_o}, {1'b0, 3'd0});
        tick;
        chk("e_idle", {bus.busy_o, bus.stage_o, bus.step_o, bus.done_o},
            {1'b0, 3'd0, 8'd0, 1'b0});
`ifdef STAGE_PERF_CNT_EN
        chk("e_stall_clr", bus.stall_cnt_o, 0);
`endif
        rst = 1'b0;
        tick;
        chk("e_nodone", {bus.done_o, bus.busy_o, bus.finished_o}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
